cache_flush_sequencer: RTL and testbench
========================================

Name: cache_flush_sequencer

Overview:
- Responder end of the cache-flush handshake, implementing the CacheFlushManager side.
- Accepts a flush request from MemoryExecutionStage and writes back and invalidates the D-cache first, then invalidates the I-cache.
- Returns a one-cycle cacheFlushComplete, which is observed by MemoryExecutionStage and ReplayQueue.
- Serialises the two cache flushes and coalesces requests that arrive while a flush is busy.

Parameters:
- TIMEOUT_CYCLES, 4096: watchdog limit per sub-cache flush phase. Used only with the optional feature.
- TIMEOUT_WIDTH, 13: counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- cacheFlushReq  in  1  one-cycle flush request pulse from MemoryExecutionStage.
- cacheFlushComplete  out  1  one-cycle pulse when the whole flush is done.
- dcFlushReq  out  1  level request to the D-cache to write back and invalidate all lines.
- dcFlushComplete  in  1  D-cache done pulse.
- icFlushReq  out  1  level request to the I-cache to invalidate all lines.
- icFlushComplete  in  1  I-cache done pulse.
- flushBusy  out  1  high whenever the FSM state is not IDLE.
- flushError  out  1  timeout flag. Present only with the optional feature.

Behaviour:
- Reset: when rst=0 at a clk edge:
  - state goes to IDLE and pending goes to 0.
  - All outputs are 0, including flushError.
  - Reset mid-flush aborts the flush with no complete pulse; sub-cache requests drop the next cycle.
- FSM states: IDLE, DC_FLUSH, IC_FLUSH, DONE.
- IDLE:
  - cacheFlushReq=1 moves to DC_FLUSH.
  - pending=1 also moves to DC_FLUSH and clears pending.
- DC_FLUSH:
  - dcFlushReq=1, held as a level.
  - dcFlushComplete=1 moves to IC_FLUSH; dcFlushReq drops the next cycle.
  - A complete pulse in the first DC_FLUSH cycle is accepted.
- IC_FLUSH:
  - icFlushReq=1, held as a level.
  - icFlushComplete=1 moves to DONE.
- DONE:
  - cacheFlushComplete=1 for exactly one cycle, as a registered state decode.
  - Then moves to IDLE.
- Sub-cache completes outside their own state are ignored.
- Minimum latency: request at cycle 0 gives DC_FLUSH at cycle 1.
  - With dcFlushComplete at cycle 1 and icFlushComplete at cycle 2, DONE and cacheFlushComplete occur at cycle 3.
- Coalescing:
  - cacheFlushReq while state is not IDLE sets pending=1.
  - Multiple such requests still leave a single pending.
  - A request in the DONE cycle also sets pending.
  - IDLE with pending=1 starts a new flush on the next cycle, with no gap besides the IDLE cycle.
- Outputs are decoded from the state register only; there is no combinational path from any input to any output.
- flushBusy = (state != IDLE).

Optional Feature:
- Macro: RSD_CACHE_FLUSH_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to DC_FLUSH and to IC_FLUSH, and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 without the matching complete, the FSM moves to DONE and flushError is set sticky.
  - flushError clears only on reset.
  - cacheFlushComplete still pulses, so the pipeline does not deadlock.
- Undefined:
  - No counter and no flushError port.
  - The FSM waits indefinitely for completes.

Decomposition:
- Shared package CacheSystemTypes holds:
  - typedef enum logic [1:0] CacheFlushPhase {IDLE, DC_FLUSH, IC_FLUSH, DONE};
  - localparam CACHE_FLUSH_TIMEOUT_CYCLES.
- Sub-module cache_flush_watchdog: a counter with clear, enable and expire outputs. It is instantiated under the macro.
- The top-level block connects to the CacheFlushManager modport of the existing flush interface.

Test Plan:
- Reset: hold rst=0 for 3 cycles with cacheFlushReq=1 -> all outputs 0, state IDLE, no flush starts.
- Basic: pulse req at cycle 0, dcFlushComplete at cycle 4, icFlushComplete at cycle 7 -> the following all hold:
  - dcFlushReq high for cycles 1-4.
  - icFlushReq high for cycles 5-7.
  - cacheFlushComplete high only at cycle 8.
  - flushBusy high for cycles 1-8.
- Back-to-back completes: req at 0, dc complete at 1, ic complete at 2 -> cacheFlushComplete at 3 only.
- Coalescing: req at 0, then extra reqs at 3 and 5, completes at 4 and 6 -> the following all hold:
  - First complete pulse at 7.
  - IDLE at 8, DC_FLUSH at 9.
  - Exactly one additional flush; total complete pulses = 2.
- Stray completes: icFlushComplete during DC_FLUSH and dcFlushComplete during IDLE -> no state change.
- Timeout (macro on, TIMEOUT_CYCLES=16): req at 0, no dc complete -> the following all hold:
  - DONE at cycle 17 and cacheFlushComplete at 17.
  - flushError=1 from 17 until the next reset.
  - No icFlushReq.
- Reset mid-flush: rst=0 at cycle 3 while in IC_FLUSH -> icFlushReq low at 4, no complete pulse, pending cleared.

Source files
------------

// File: rtl/cache_flush_sequencer_pkg.sv
// rtl/cache_flush_sequencer_pkg.sv - shared cache-system types for the flush sequencer
// Purpose: flush phase encoding and default watchdog limits, imported as
//          CacheSystemTypes::* by the flush sequencer files.
// Ports:   none (package).
package CacheSystemTypes;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DC_FLUSH = 2'd1,
        IC_FLUSH = 2'd2,
        DONE     = 2'd3
    } CacheFlushPhase;

    localparam int CACHE_FLUSH_TIMEOUT_CYCLES = 4096;
    localparam int CACHE_FLUSH_TIMEOUT_WIDTH  = 13;

endpackage

// File: rtl/cache_flush_sequencer_if.sv
// rtl/cache_flush_sequencer_if.sv - cache-flush handshake bundle
// Purpose: groups the flush request/complete handshake between
//          MemoryExecutionStage, the CacheFlushManager and the two caches.
// Modports:
//   CacheFlushManager - responder (the flush sequencer): takes cacheFlushReq and
//                       sub-cache completes, drives cache requests, complete,
//                       busy and (with RSD_CACHE_FLUSH_TIMEOUT_EN) flushError.
//   Requester         - the opposite side (pipeline + caches).
// Optional: RSD_CACHE_FLUSH_TIMEOUT_EN adds flushError.
interface cache_flush_sequencer_if;

    logic cacheFlushReq;
    logic cacheFlushComplete;
    logic dcFlushReq;
    logic dcFlushComplete;
    logic icFlushReq;
    logic icFlushComplete;
    logic flushBusy;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
    logic flushError;
`endif

    modport CacheFlushManager (
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
        output flushError,
`endif
        input  cacheFlushReq,
        input  dcFlushComplete,
        input  icFlushComplete,
        output cacheFlushComplete,
        output dcFlushReq,
        output icFlushReq,
        output flushBusy
    );

    modport Requester (
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
        input  flushError,
`endif
        output cacheFlushReq,
        output dcFlushComplete,
        output icFlushComplete,
        input  cacheFlushComplete,
        input  dcFlushReq,
        input  icFlushReq,
        input  flushBusy
    );

endinterface

// File: rtl/cache_flush_sequencer_watchdog.sv
// rtl/cache_flush_sequencer_watchdog.sv - per-phase flush watchdog counter
// Purpose: module cache_flush_watchdog counts cycles spent in one sub-cache
//          flush phase and flags expiry at TIMEOUT_CYCLES-1.
// Ports:
//   clk, rst - clock, synchronous active-low reset
//   clr      - restart the count at 0 (phase entry)
//   en       - count this cycle (inside a flush phase)
//   expire   - current count equals TIMEOUT_CYCLES-1
module cache_flush_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_WIDTH  = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Taken from the register only so the FSM next-state logic stays loop-free.
    assign expire = (count_q == LAST);

endmodule

// File: rtl/cache_flush_sequencer.sv
// rtl/cache_flush_sequencer.sv - CacheFlushManager: serialised D-cache then I-cache flush
// Purpose: accepts a flush request pulse, writes back/invalidates the D-cache,
//          then invalidates the I-cache, then pulses cacheFlushComplete once.
//          Requests arriving while busy coalesce into a single pending flush.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   port - cache_flush_sequencer_if.CacheFlushManager handshake bundle
// Optional: RSD_CACHE_FLUSH_TIMEOUT_EN adds a per-phase watchdog and a sticky
//           flushError; on expiry the flush is forced to DONE.
module cache_flush_sequencer
    import CacheSystemTypes::*;
#(
    parameter int TIMEOUT_CYCLES = CACHE_FLUSH_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = CACHE_FLUSH_TIMEOUT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    cache_flush_sequencer_if.CacheFlushManager port
);

    // Elaboration-time sanity: the counter must be able to hold TIMEOUT_CYCLES-1.
    if ((TIMEOUT_CYCLES < 2) || ((64'd1 << TIMEOUT_WIDTH) <= 64'(TIMEOUT_CYCLES))) begin : g_bad_timeout_cfg
        CacheFlushPhase invalid_timeout_configuration;
    end

    CacheFlushPhase state_q, state_d;
    logic pending_q, pending_d;
    logic dc_req_q, ic_req_q, complete_q, busy_q;

`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
    logic error_q, error_d;
    logic wd_clr, wd_en, wd_expire;

    // Restart on entry into either sub-cache phase, count while inside one.
    assign wd_clr = (state_d != state_q) && ((state_d == DC_FLUSH) || (state_d == IC_FLUSH));
    assign wd_en  = (state_q == DC_FLUSH) || (state_q == IC_FLUSH);

    cache_flush_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
        error_d   = error_q;
`endif
        // Any request seen while a flush is in flight (DONE included) folds
        // into one pending flush.
        if ((state_q != IDLE) && port.cacheFlushReq) begin
            pending_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (port.cacheFlushReq || pending_q) begin
                    state_d   = DC_FLUSH;
                    pending_d = 1'b0;
                end
            end
            DC_FLUSH: begin
                if (port.dcFlushComplete) begin
                    state_d = IC_FLUSH;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
                end else if (wd_expire) begin
                    state_d = DONE;
                    error_d = 1'b1;
`endif
                end
            end
            IC_FLUSH: begin
                if (port.icFlushComplete) begin
                    state_d = DONE;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
                end else if (wd_expire) begin
                    state_d = DONE;
                    error_d = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up with
    // state_q and never see an input combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            dc_req_q   <= 1'b0;
            ic_req_q   <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            dc_req_q   <= (state_d == DC_FLUSH);
            ic_req_q   <= (state_d == IC_FLUSH);
            complete_q <= (state_d == DONE);
            busy_q     <= (state_d != IDLE);
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
            error_q    <= error_d;
`endif
        end
    end

    assign port.dcFlushReq         = dc_req_q;
    assign port.icFlushReq         = ic_req_q;
    assign port.cacheFlushComplete = complete_q;
    assign port.flushBusy          = busy_q;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
    assign port.flushError         = error_q;
`endif

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// tb/tb_cache_flush_sequencer.sv - self-checking bench for cache_flush_sequencer
module tb_cache_flush_sequencer;

    localparam int TB_TC = 16;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_flush_sequencer_if fif ();

    cache_flush_sequencer #(
        .TIMEOUT_CYCLES (TB_TC),
        .TIMEOUT_WIDTH  (13)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .port (fif.CacheFlushManager)
    );

    int checks = 0;
    int errors = 0;

    // Reference: which job the sequencer is doing (0 idle, 1 D-cache,
    // 2 I-cache, 3 reporting), whether another flush is owed, how long the
    // current sub-cache job has run, and the sticky timeout flag.
    int m_phase = 0;
    bit m_pend  = 1'b0;
    int m_age   = 0;
    bit m_err   = 1'b0;
    bit chk_en  = 1'b0;

    logic hist_dc [64];
    logic hist_ic [64];
    logic hist_cmp[64];
    logic hist_busy[64];
    logic hist_err[64];

    task automatic check_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic q, input logic d, input logic i);
        if (!r) begin
            m_phase = 0;
            m_pend  = 1'b0;
            m_age   = 0;
            m_err   = 1'b0;
            return;
        end
        if (m_phase != 0 && q) m_pend = 1'b1;
        case (m_phase)
            0: if (q || m_pend) begin
                m_phase = 1;
                m_pend  = 1'b0;
                m_age   = 0;
            end
            1, 2: begin
                if ((m_phase == 1 && d) || (m_phase == 2 && i)) begin
                    m_phase = m_phase + 1;
                    m_age   = 0;
                end else if (TO_EN && m_age == TB_TC - 1) begin
                    m_phase = 3;
                    m_err   = 1'b1;
                end else begin
                    m_age++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("dcFlushReq", fif.dcFlushReq, m_phase == 1);
            check_bit("icFlushReq", fif.icFlushReq, m_phase == 2);
            check_bit("cacheFlushComplete", fif.cacheFlushComplete, m_phase == 3);
            check_bit("flushBusy", fif.flushBusy, m_phase != 0);
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
            check_bit("flushError", fif.flushError, m_err);
`endif
        end
    end

    task automatic cyc(input logic r, input logic q, input logic d, input logic i);
        rst                 = r;
        fif.cacheFlushReq   = q;
        fif.dcFlushComplete = d;
        fif.icFlushComplete = i;
        @(posedge clk);
        model_step(r, q, d, i);
        #1;
    endtask

    // Cycle 0 is the first cycle of the run; hist[t] holds outputs seen in cycle t.
    task automatic run_dir(input int q0, input int q1, input int q2,
                           input int d0, input int d1, input int i0, input int i1,
                           input int rt, input int n);
        for (int t = 0; t < n; t++) begin
            hist_dc[t]   = fif.dcFlushReq;
            hist_ic[t]   = fif.icFlushReq;
            hist_cmp[t]  = fif.cacheFlushComplete;
            hist_busy[t] = fif.flushBusy;
`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
            hist_err[t]  = fif.flushError;
`else
            hist_err[t]  = 1'b0;
`endif
            cyc(!(t == rt), (t == q0) || (t == q1) || (t == q2),
                (t == d0) || (t == d1), (t == i0) || (t == i1));
        end
    endtask

    function automatic int pulses(input int n);
        int s = 0;
        for (int t = 0; t < n; t++) s += int'(hist_cmp[t]);
        return s;
    endfunction

    initial begin
        rst = 1'b0;
        fif.cacheFlushReq   = 1'b0;
        fif.dcFlushComplete = 1'b0;
        fif.icFlushComplete = 1'b0;

        // Reset held 3 cycles with a request asserted: nothing starts.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        check_bit("rst_busy", fif.flushBusy, 1'b0);
        check_bit("rst_dc", fif.dcFlushReq, 1'b0);
        check_bit("rst_cmp", fif.cacheFlushComplete, 1'b0);
        run_dir(-1, -1, -1, -1, -1, -1, -1, -1, 3);
        for (int t = 0; t < 3; t++) check_bit($sformatf("rst_idle_%0d", t), hist_busy[t], 1'b0);

        // Basic: req 0, dc done 4, ic done 7.
        run_dir(0, -1, -1, 4, -1, 7, -1, -1, 12);
        for (int t = 0; t < 12; t++) begin
            check_bit($sformatf("basic_dc_%0d", t), hist_dc[t], t >= 1 && t <= 4);
            check_bit($sformatf("basic_ic_%0d", t), hist_ic[t], t >= 5 && t <= 7);
            check_bit($sformatf("basic_cmp_%0d", t), hist_cmp[t], t == 8);
            check_bit($sformatf("basic_busy_%0d", t), hist_busy[t], t >= 1 && t <= 8);
        end

        // Back-to-back completes: minimum latency.
        run_dir(0, -1, -1, 1, -1, 2, -1, -1, 6);
        for (int t = 0; t < 6; t++) check_bit($sformatf("b2b_cmp_%0d", t), hist_cmp[t], t == 3);

        // Coalescing: two extra requests while busy yield one more flush.
        run_dir(0, 3, 5, 4, 10, 6, 11, -1, 16);
        check_bit("coal_cmp7", hist_cmp[7], 1'b1);
        check_bit("coal_idle8", hist_busy[8], 1'b0);
        check_bit("coal_dc9", hist_dc[9], 1'b1);
        check_bit("coal_cmp12", hist_cmp[12], 1'b1);
        check_int("coal_pulses", pulses(16), 2);

        // Stray completes: dc in IDLE (cycle 0), ic during DC_FLUSH (cycle 2).
        run_dir(0, -1, -1, 0, 4, 2, 6, -1, 10);
        check_bit("stray_dc1", hist_dc[1], 1'b1);
        check_bit("stray_dc3", hist_dc[3], 1'b1);
        check_bit("stray_ic3", hist_ic[3], 1'b0);
        check_bit("stray_cmp7", hist_cmp[7], 1'b1);
        run_dir(-1, -1, -1, 1, -1, 2, -1, -1, 5);
        for (int t = 0; t < 5; t++) check_bit($sformatf("stray_idle_%0d", t), hist_busy[t], 1'b0);

        // Reset mid-flush in IC_FLUSH with a pending request.
        run_dir(0, 2, -1, 1, -1, -1, -1, 3, 10);
        check_bit("rmid_ic3", hist_ic[3], 1'b1);
        check_bit("rmid_ic4", hist_ic[4], 1'b0);
        for (int t = 4; t < 10; t++) check_bit($sformatf("rmid_busy_%0d", t), hist_busy[t], 1'b0);
        check_int("rmid_pulses", pulses(10), 0);

`ifdef RSD_CACHE_FLUSH_TIMEOUT_EN
        // Timeout: no dc complete ever.
        run_dir(0, -1, -1, -1, -1, -1, -1, -1, 22);
        check_bit("to_cmp16", hist_cmp[16], 1'b0);
        check_bit("to_cmp17", hist_cmp[17], 1'b1);
        check_bit("to_err16", hist_err[16], 1'b0);
        check_bit("to_err17", hist_err[17], 1'b1);
        check_bit("to_err21", hist_err[21], 1'b1);
        check_bit("to_dc16", hist_dc[16], 1'b1);
        for (int t = 0; t < 22; t++) check_bit($sformatf("to_ic_%0d", t), hist_ic[t], 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_bit("to_err_cleared", fif.flushError, 1'b0);
`endif

        // Randomised traffic; completion probability varies per block so that
        // long stalls (and timeouts when enabled) occur.
        for (int blk = 0; blk < 15; blk++) begin
            int pd;
            case (blk % 3)
                0: pd = 30;
                1: pd = 3;
                default: pd = 0;
            endcase
            for (int k = 0; k < 200; k++) begin
                cyc($urandom_range(149) != 0, $urandom_range(5) == 0,
                    $urandom_range(99) < pd, $urandom_range(99) < pd);
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
